// File: rtl/poisson_array.sv
// Time-multiplexed Poisson spike source: one channel evaluated per cycle after tick, spikes emitted as AER events.
// Each spike costs one cycle plus however long spike_ready stays low; the scan stalls while an event is pending.
module poisson_array #(
  parameter int                    N_CH           = 16,
  parameter int                    ACTIVITY_LEN   = 9,
  parameter int                    REFRACTORY_LEN = 4,
  parameter int                    REFRACTORY_PER = 4,
  parameter int                    SHIFT          = 4,
  parameter int                    LFSR_LEN       = 16,
  parameter logic [LFSR_LEN-1:0]   LFSR_SEED      = 16'hACE1,
  parameter int                    CH_W           = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_addr,
  input  logic [ACTIVITY_LEN-1:0] wr_activity,
  output logic                    busy,
  output logic                    spike_valid,
  input  logic                    spike_ready,
  output logic [CH_W-1:0]         spike_addr,
  output logic                    done,
  output logic                    overrun
);

  localparam int CMP_W = (ACTIVITY_LEN + SHIFT > LFSR_LEN) ? ACTIVITY_LEN + SHIFT : LFSR_LEN;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t                    state;
  logic [ACTIVITY_LEN-1:0]   act  [N_CH];
  logic [REFRACTORY_LEN-1:0] refr [N_CH];
  logic [LFSR_LEN-1:0]       lfsr;
  logic [LFSR_LEN-1:0]       lfsr_next;
  logic [CH_W-1:0]           ch;
  logic                      last_ch;
  logic [CMP_W-1:0]          act_scaled;
  logic [CMP_W-1:0]          lfsr_ext;
  logic                      spike;

  // Reads the pre-write activity, so a same-cycle write to ch only affects later scans.
  always_comb begin
    act_scaled = CMP_W'(act[ch]) << SHIFT;
    lfsr_ext   = CMP_W'(lfsr);
    spike      = (act_scaled >= lfsr_ext) && (refr[ch] == '0);
    lfsr_next  = {lfsr[LFSR_LEN-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    last_ch    = (ch == CH_W'(N_CH - 1));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) act[i] <= '0;
    end else if (wr_en) begin
      act[wr_addr] <= wr_activity;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ch          <= '0;
      lfsr        <= LFSR_SEED;
      spike_valid <= 1'b0;
      spike_addr  <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N_CH; i++) refr[i] <= '0;
    end else begin
      done <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            ch    <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          lfsr <= lfsr_next;
          if (spike) begin
            refr[ch]    <= REFRACTORY_LEN'(REFRACTORY_PER);
            spike_valid <= 1'b1;
            spike_addr  <= ch;
            state       <= EMIT;
          end else begin
            if (refr[ch] != '0) refr[ch] <= refr[ch] - REFRACTORY_LEN'(1);
            if (last_ch) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              ch <= ch + CH_W'(1);
            end
          end
        end
        EMIT: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            if (last_ch) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poisson_array.sv
// Bench for poisson_array: randomized handshake timing checked against a scan-level reference model.
module tb_poisson_array;
  localparam int N_CH  = 16;
  localparam int CH_W  = 4;
  localparam int AW    = 13;
  localparam int SHIFT = 4;
  localparam int RPER  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tick = 1'b0;
  logic            wr_en = 1'b0;
  logic [CH_W-1:0] wr_addr = '0;
  logic [AW-1:0]   wr_activity = '0;
  logic            busy, spike_valid, done, overrun;
  logic            spike_ready = 1'b0;
  logic [CH_W-1:0] spike_addr;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          act_m  [N_CH];
  int          refr_m [N_CH];
  logic [15:0] lfsr_m;
  int          exp_q[$];

  // observations from the most recent scan
  int obs_q[$];
  int obs_done, obs_busy, obs_stall;
  bit obs_to, obs_unstable;

  poisson_array #(.N_CH(N_CH), .ACTIVITY_LEN(AW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_activity(wr_activity), .busy(busy), .spike_valid(spike_valid),
    .spike_ready(spike_ready), .spike_addr(spike_addr), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      act_m[i]  = 0;
      refr_m[i] = 0;
    end
    lfsr_m = 16'hACE1;
  endtask

  // One full scan; wc/wv model a write landing in the cycle channel wc is evaluated.
  task automatic model_scan(input int wc, input int wv);
    exp_q = {};
    for (int c = 0; c < N_CH; c++) begin
      longint scaled = longint'(act_m[c]) << SHIFT;
      bit fire = (scaled >= longint'(lfsr_m)) && (refr_m[c] == 0);
      if (fire) begin
        exp_q.push_back(c);
        refr_m[c] = RPER;
      end else if (refr_m[c] > 0) begin
        refr_m[c] = refr_m[c] - 1;
      end
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      if (c == wc) act_m[c] = wv;
    end
  endtask

  function automatic bit q_eq();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input int c, input int v);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = CH_W'(c);
    wr_activity = AW'(v);
    @(negedge clk);
    wr_en = 1'b0;
    act_m[c] = v;
  endtask

  // hold_low < 0: random ready; otherwise ready stays low for hold_low valid cycles per event.
  task automatic do_scan(input int hold_low, input int tick_at, input int wr_at,
                         input int wr_ch, input int wr_val);
    int cyc, lowleft;
    bit pv, phs;
    logic [CH_W-1:0] pa;
    obs_q = {}; obs_done = -1; obs_busy = 0; obs_stall = 0; obs_to = 0; obs_unstable = 0;
    pv = 0; phs = 0; pa = '0; lowleft = hold_low;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc = 1;
    forever begin
      tick = (cyc == tick_at);
      wr_en = (cyc == wr_at);
      wr_addr = CH_W'(wr_ch);
      wr_activity = AW'(wr_val);
      if (busy) obs_busy++;
      if (pv && !phs && (!spike_valid || spike_addr !== pa)) obs_unstable = 1;
      if (spike_valid) begin
        if (hold_low < 0) spike_ready = ($urandom_range(3) != 0);
        else begin
          spike_ready = (lowleft == 0);
          if (lowleft > 0) lowleft--;
        end
      end else begin
        spike_ready = $urandom_range(1) != 0;
      end
      if (spike_valid && !spike_ready) obs_stall++;
      if (spike_valid && spike_ready) begin
        obs_q.push_back(int'(spike_addr));
        lowleft = hold_low;
      end
      pv = spike_valid; phs = spike_valid && spike_ready; pa = spike_addr;
      if (done) begin
        obs_done = cyc;
        break;
      end
      if (cyc >= 2000) begin
        obs_to = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    tick = 1'b0; wr_en = 1'b0; spike_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", spike_valid); end
    total++; if (spike_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", spike_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    model_scan(-1, 0);
    do_scan(0, -1, -1, 0, 0);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL idle_scan_events got=%0d want=0", obs_q.size()); end
    total++; if (obs_busy != N_CH) begin bad++; $display("FAIL idle_scan_busy got=%0d want=%0d", obs_busy, N_CH); end
    total++; if (obs_to || obs_done != N_CH + 1) begin bad++; $display("FAIL idle_scan_done got=%0d want=%0d", obs_done, N_CH + 1); end
  endtask

  task automatic test_guaranteed();
    do_reset();
    wr(3, 8191);
    for (int s = 0; s < 12; s++) begin
      int want_n = (s % 5 == 0) ? 1 : 0;
      model_scan(-1, 0);
      do_scan(0, -1, -1, 0, 0);
      total++;
      if (obs_q.size() != want_n || (want_n == 1 && obs_q[0] != 3) || !q_eq()) begin
        bad++; $display("FAIL guaranteed_scan%0d got_n=%0d want_n=%0d", s, obs_q.size(), want_n);
      end
      total++;
      if (obs_to || obs_done != N_CH + 1 + want_n) begin
        bad++; $display("FAIL guaranteed_done%0d got=%0d want=%0d", s, obs_done, N_CH + 1 + want_n);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    wr(3, 8191);
    model_scan(-1, 0);
    do_scan(7, -1, -1, 0, 0);
    total++; if (obs_q.size() != 1 || obs_q[0] != 3) begin bad++; $display("FAIL bp_event got_n=%0d want addr 3", obs_q.size()); end
    total++; if (obs_unstable) begin bad++; $display("FAIL bp_stable got=unstable want=stable"); end
    total++; if (obs_stall != 7) begin bad++; $display("FAIL bp_stall got=%0d want=7", obs_stall); end
    total++; if (obs_to || obs_done != N_CH + 1 + 1 + 7) begin bad++; $display("FAIL bp_done got=%0d want=%0d", obs_done, N_CH + 9); end
  endtask

  task automatic test_statistics();
    do_reset();
    for (int c = 0; c < N_CH; c++) wr(c, 256);
    for (int s = 0; s < 2000; s++) begin
      model_scan(-1, 0);
      do_scan(-1, -1, -1, 0, 0);
      total++;
      if (!q_eq()) begin
        bad++; $display("FAIL stats_events scan%0d got_n=%0d want_n=%0d", s, obs_q.size(), exp_q.size());
      end
      total++;
      if (obs_to || obs_done != N_CH + 1 + obs_q.size() + obs_stall) begin
        bad++; $display("FAIL stats_done scan%0d got=%0d want=%0d", s, obs_done, N_CH + 1 + obs_q.size() + obs_stall);
      end
      total++;
      if (obs_unstable) begin bad++; $display("FAIL stats_stable scan%0d got=unstable want=stable", s); end
    end
  endtask

  task automatic test_overrun();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre got=%b want=0", overrun); end
    model_scan(-1, 0);
    do_scan(-1, 5, -1, 0, 0);
    total++; if (!q_eq()) begin bad++; $display("FAIL overrun_events got_n=%0d want_n=%0d", obs_q.size(), exp_q.size()); end
    total++;
    if (obs_to || obs_done != N_CH + 1 + obs_q.size() + obs_stall) begin
      bad++; $display("FAIL overrun_done got=%0d want=%0d", obs_done, N_CH + 1 + obs_q.size() + obs_stall);
    end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
    model_scan(-1, 0);
    do_scan(-1, -1, -1, 0, 0);
    total++; if (overrun !== 1'b1 || !q_eq()) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    do_reset();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b want=0", overrun); end
  endtask

  task automatic test_collision();
    int waited;
    bit seen, stray;
    do_reset();
    wr(2, 8191);
    model_scan(2, 0);
    do_scan(0, -1, 3, 2, 0);
    total++; if (obs_q.size() != 1 || obs_q[0] != 2 || !q_eq()) begin bad++; $display("FAIL coll_spike got_n=%0d want ch2", obs_q.size()); end
    for (int s = 0; s < 6; s++) begin
      model_scan(-1, 0);
      do_scan(-1, -1, -1, 0, 0);
      total++; if (obs_q.size() != 0 || !q_eq()) begin bad++; $display("FAIL coll_after%0d got_n=%0d want_n=0", s, obs_q.size()); end
    end
    // abort an event that is still waiting for ready
    wr(5, 8191);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    seen = 0;
    for (waited = 0; waited < 40 && !seen; waited++) begin
      if (spike_valid) seen = 1;
      else @(negedge clk);
    end
    total++; if (!seen || spike_addr !== 4'd5) begin bad++; $display("FAIL abort_pending seen=%0d addr=%0d want addr 5", seen, spike_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (spike_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_state valid=%b busy=%b done=%b want 0 0 0", spike_valid, busy, done);
    end
    stray = 0;
    spike_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done || spike_valid || busy) stray = 1;
    end
    spike_ready = 1'b0;
    total++; if (stray) begin bad++; $display("FAIL abort_quiet got=activity want=none"); end
    model_reset();
    model_scan(-1, 0);
    do_scan(-1, -1, -1, 0, 0);
    total++; if (obs_q.size() != 0 || obs_to || obs_done != N_CH + 1) begin bad++; $display("FAIL abort_rescan got_n=%0d done=%0d want 0/%0d", obs_q.size(), obs_done, N_CH + 1); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_guaranteed();
    test_backpressure();
    test_statistics();
    test_overrun();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/poisson_array.md
# poisson_array

Multi-channel, time-multiplexed Poisson spike source for the neuromorphic processor input stage. It holds per-channel activity (rate) and refractory state in internal registers. On each time-step `tick` it scans all channels with one shared LFSR and emits an address-event for every spiking channel over a valid/ready handshake. Rates can be rewritten at any time through a write port without stalling the scan.

## Interface
Parameters:
- `N_CH`, 16: number of channels (≥2); `CH_W = $clog2(N_CH)`.
- `ACTIVITY_LEN`, 9: width of per-channel activity value.
- `REFRACTORY_LEN`, 4: width of per-channel refractory counter.
- `REFRACTORY_PER`, 4: refractory load value after a spike; must be < 2^REFRACTORY_LEN.
- `SHIFT`, 4: left shift applied to activity before comparison.
- `LFSR_LEN`, 16: LFSR width; fixed taps for 16 (x^16+x^14+x^13+x^11+1).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle pulse that starts a scan of all channels.
- `wr_en` in 1: write activity of channel `wr_addr`.
- `wr_addr` in CH_W: channel to write.
- `wr_activity` in ACTIVITY_LEN: new activity value.
- `busy` out 1: scan in progress (state ≠ IDLE).
- `spike_valid` out 1: spike event available.
- `spike_ready` in 1: consumer accepts event.
- `spike_addr` out CH_W: channel index of event.
- `done` out 1: one-cycle pulse when a scan completes.
- `overrun` out 1: sticky; set when `tick` arrives while busy; cleared only by reset.

## Operation
- State per channel: `act[ch]` (ACTIVITY_LEN), `refr[ch]` (REFRACTORY_LEN).
- FSM states: IDLE, SCAN, EMIT.
  - IDLE + `tick`: `ch` is set to 0 and the FSM enters SCAN.
  - SCAN evaluates channel `ch` in one cycle:
    - spike = (`act[ch]` << SHIFT, zero-extended to max(ACTIVITY_LEN+SHIFT, LFSR_LEN)) ≥ `lfsr` (zero-extended), AND `refr[ch]` == 0.
    - `refr[ch]` next: REFRACTORY_PER if spike; else `refr-1` if nonzero; else 0.
    - LFSR advances exactly once per channel evaluated: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
    - On spike: `spike_valid` is set to 1, `spike_addr` to `ch`, and the FSM goes to EMIT.
    - No spike and `ch` == N_CH-1: FSM goes to IDLE and `done` pulses. Otherwise `ch` increments and the FSM stays in SCAN.
  - EMIT holds `spike_valid`/`spike_addr` stable until `spike_ready`. On handshake, `spike_valid` clears. Then either `ch` increments and the FSM returns to SCAN, or, if `ch` == N_CH-1, the FSM goes to IDLE and `done` pulses.
- `tick` while busy is ignored, and `overrun` is set to 1.
- Write port:
  - `act[wr_addr] <= wr_activity` in any state; `refr` is unaffected.
  - If the write hits the channel being evaluated in the same cycle, evaluation uses the old value and the stored value becomes the new one.
- Activity 0 never spikes, because the LFSR is never 0.
- Reset:
  - All `act` and `refr` are 0, `lfsr` = LFSR_SEED, FSM is IDLE, `ch` = 0.
  - `spike_valid`, `spike_addr`, `done`, `busy` and `overrun` are 0.
  - Reset mid-scan or mid-EMIT aborts immediately: no `done` pulse, and any pending event is dropped.

## Timing
- `tick` sampled at edge t: `busy` = 1 from cycle t+1, and channel 0 is evaluated in cycle t+1.
- Scan with no spikes: channel k is evaluated in cycle t+1+k. `done` is high in cycle t+1+N_CH, and `busy` is 0 from that same cycle.
- Each spike adds 1 cycle plus the number of cycles `spike_ready` stays low.
- `spike_valid` is high starting the cycle after the spiking channel's evaluation.
- `spike_ready` high during a non-valid cycle has no effect.
- Refractory counts in scans: a channel that spikes in scan s is blocked for REFRACTORY_PER scans. Minimum spike period is REFRACTORY_PER+1 scans.

## Test plan
- Reset check: after reset, all outputs are 0. A single tick with all activity 0 gives `busy` high for 16 cycles, `done` at t+17, and no `spike_valid`.
- Guaranteed-spike case, with override ACTIVITY_LEN=13 (8191<<4 ≥ any LFSR value): set ch 3 = 8191 and tick 12 times with `spike_ready`=1. Ch 3 must spike in scans 0, 5 and 10 only, with `spike_addr`=3.
- Backpressure: same setup, `spike_ready` held low for 7 cycles. `spike_valid` and `spike_addr` stay stable, and `done` is delayed by exactly 1+7 cycles compared with the no-spike scan time.
- Statistics: all 16 channels at activity 256 (4096/65536) over 2000 scans, compared against a cycle-accurate reference model. The event sequence must match exactly, including LFSR advancing once per channel.
- Tick while busy: pulse `tick` in cycle t+5 of a scan. The scan is unaffected, and `overrun` becomes 1 and stays 1 until reset.
- Write collision: write ch 2 = 0 in the cycle ch 2 is evaluated, with old value 8191 (13-bit override). Ch 2 spikes in that scan and never spikes afterwards; reset mid-EMIT drops the event and gives no `done`.
